// File: rtl/mat_mul_sequencer.sv
// -----------------------------------------------------------------------------
// mat_mul_sequencer
//
// Purpose: sequences one matrix-multiply job on a register-mapped multiplier
// slave. Operand pairs arrive on a valid/ready stream and are written to the
// slave (A -> 0x00, B -> 0x01). The multiplier (0x03) and adder (0x04) are then
// kicked. After adder_opdone, each result index is selected (0x06), read back
// from m_rdata and offered on a valid/ready result stream. Finally the slave
// is cleared (0x05 = 1, then 0x05 = 0) and done pulses for one cycle.
//
// Configuration macro: TIMEOUT_EN. When defined, a watchdog bounds the WAIT
// state to TIMEOUT_CYCLES cycles; expiry sets the sticky err flag, skips all
// reads and goes straight to the clear sequence. When undefined, WAIT has no
// bound and err is tied to 0.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             job request, only looked at in IDLE
//   in_valid/in_ready operand stream, in_a/in_b carry one pair
//   out_valid/ready   result stream, out_data/out_idx carry one result
//   busy              high whenever the sequencer is not IDLE
//   done              one-cycle pulse on return to IDLE after a job
//   err               sticky watchdog flag, cleared by the next start
//   m_sel/m_wr/m_addr/m_wdata  register-write bus to the slave
//   m_rdata           slave read data
//   adder_opdone      adder completion from the slave
//   dbg_state         current FSM state, for observation only
//
// Handshake rule (both streams): a transfer happens on a rising edge where
// valid and ready are both high. The sender keeps its payload stable while
// valid is high and ready is low; ready never depends on the same-cycle
// value of the partner's valid.
// -----------------------------------------------------------------------------
module mat_mul_sequencer #(
  parameter int NUM_PAIRS      = 8,
  parameter int NUM_RESULTS    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_idx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_sel,
  output logic        m_wr,
  output logic [7:0]  m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        adder_opdone,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_MSTART = 4'd3,
    S_ASTART = 4'd4,
    S_WAIT   = 4'd5,
    S_RADDR  = 4'd6,
    S_RWAIT  = 4'd7,
    S_RCAP   = 4'd8,
    S_CLR1   = 4'd9,
    S_CLR0   = 4'd10
  } state_t;

  localparam logic [3:0] LAST_PAIR   = 4'(NUM_PAIRS - 1);
  localparam logic [3:0] LAST_RESULT = 4'(NUM_RESULTS - 1);

  state_t      state;
  logic [3:0]  pair_cnt;
  logic [3:0]  idx;
  logic [31:0] b_q;

`ifdef TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);
  logic [WCW-1:0] wait_cnt;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pair_cnt  <= '0;
      idx       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            pair_cnt <= '0;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end
        S_LOAD_A: begin
          // The A write goes out combinationally this cycle; B is held for
          // the following LOAD_B write.
          if (in_valid) begin
            b_q      <= in_b;
            in_ready <= 1'b0;
            state    <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          pair_cnt <= pair_cnt + 4'd1;
          if (pair_cnt == LAST_PAIR) begin
            state <= S_MSTART;
          end else begin
            state    <= S_LOAD_A;
            in_ready <= 1'b1;
          end
        end
        S_MSTART: state <= S_ASTART;
        S_ASTART: begin
          state <= S_WAIT;
`ifdef TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          // adder_opdone wins over a watchdog expiry in the same cycle.
          if (adder_opdone) begin
            state <= S_RADDR;
          end
`ifdef TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            err_q <= 1'b1;
            state <= S_CLR1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RADDR: state <= S_RWAIT;
        S_RWAIT: begin
          // Slave read data is valid one cycle after the index write.
          out_data  <= m_rdata;
          out_idx   <= idx[2:0];
          out_valid <= 1'b1;
          state     <= S_RCAP;
        end
        S_RCAP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= idx + 4'd1;
            state     <= (idx == LAST_RESULT) ? S_CLR1 : S_RADDR;
          end
        end
        S_CLR1: state <= S_CLR0;
        S_CLR0: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Slave write bus. Decoded from the registered state; only the LOAD_A
  // write also depends on the live in_valid/in_a so the A operand is written
  // in its handshake cycle. Address and data stay at zero when not selected.
  always_comb begin
    m_sel   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 8'h00;
    m_wdata = 32'h0;
    case (state)
      S_LOAD_A: begin
        if (in_valid) begin
          m_sel   = 1'b1;
          m_wr    = 1'b1;
          m_addr  = 8'h00;
          m_wdata = in_a;
        end
      end
      S_LOAD_B: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h01;
        m_wdata = b_q;
      end
      S_MSTART: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h03;
        m_wdata = 32'h1;
      end
      S_ASTART: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h04;
        m_wdata = 32'h1;
      end
      S_RADDR: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h06;
        m_wdata = {28'h0, idx};
      end
      S_CLR1: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h05;
        m_wdata = 32'h1;
      end
      S_CLR0: begin
        m_sel   = 1'b1;
        m_wr    = 1'b1;
        m_addr  = 8'h05;
        m_wdata = 32'h0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mat_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mat_mul_sequencer
//
// Drives randomized jobs into mat_mul_sequencer and compares every slave bus
// write and every delivered result against queues built from the job
// description, plus start-to-done latency from the cycle-count formula.
// -----------------------------------------------------------------------------
module tb_mat_mul_sequencer;

  localparam int NP = 8;
  localparam int NR = 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;
  logic        m_sel;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        adder_opdone;
  logic [3:0]  dbg_state;

  initial forever #5 clk = ~clk;

  mat_mul_sequencer #(
    .NUM_PAIRS(NP),
    .NUM_RESULTS(NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .busy(busy),
    .done(done),
    .err(err),
    .m_sel(m_sel),
    .m_wr(m_wr),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .adder_opdone(adder_opdone),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];   // {addr, data} of expected bus writes, in order
  logic [34:0] res_q[$];   // {idx, data} of expected results, in order
  logic [31:0] a_arr[NP];
  logic [31:0] b_arr[NP];
  logic [31:0] res_mem[NR];

  int cfg_w;
  bit cfg_rand;
  int cfg_gap_pair;
  int cfg_gap_len;
  int cfg_stall_idx;
  int cfg_stall_len;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int job_latency(input int w);
    return 1 + 2 * NP + 2 + w + 3 * NR + 2;
  endfunction

  // ---------------- operand driver ----------------
  initial begin : in_drv
    int ptr;
    int gap_left;
    bit gap_done;
    bit hs;
    bit restart;
    ptr = 0; gap_left = 0; gap_done = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0;
    forever begin
      @(negedge clk);
      hs      = in_valid && in_ready;
      restart = start && !busy && !reset;
      @(posedge clk); #1;
      if (restart) begin
        ptr = 0; gap_left = 0; gap_done = (cfg_gap_len == 0);
      end else if (hs) begin
        ptr++;
      end
      if (gap_left > 0) begin
        gap_left--;
        in_valid = 1'b0;
      end else if (!gap_done && ptr == cfg_gap_pair) begin
        gap_done = 1'b1;
        gap_left = cfg_gap_len - 1;
        in_valid = 1'b0;
      end else begin
        in_valid = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      in_a = a_arr[(ptr < NP) ? ptr : NP - 1];
      in_b = b_arr[(ptr < NP) ? ptr : NP - 1];
    end
  end

  // ---------------- result-ready driver ----------------
  initial begin : rdy_drv
    int stall_left;
    bit stall_done;
    bit restart;
    stall_left = 0; stall_done = 1'b1; out_ready = 1'b1;
    forever begin
      @(negedge clk);
      restart = start && !busy && !reset;
      @(posedge clk); #1;
      if (restart) begin
        stall_left = 0; stall_done = (cfg_stall_len == 0);
      end
      if (stall_left > 0) begin
        stall_left--;
        out_ready = 1'b0;
      end else if (!stall_done && out_valid && int'(out_idx) == cfg_stall_idx) begin
        stall_done = 1'b1;
        stall_left = cfg_stall_len - 1;
        out_ready  = 1'b0;
      end else begin
        out_ready = cfg_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- adder completion: high in the cfg_w-th WAIT cycle ----------------
  initial begin : opdone_drv
    int  wait_k;
    bit  astart_seen;
    wait_k = 0; adder_opdone = 1'b0;
    forever begin
      @(negedge clk);
      astart_seen = !reset && m_sel && m_wr && (m_addr == 8'h04);
      @(posedge clk); #1;
      if (reset) wait_k = 0;
      else if (astart_seen) wait_k = 1;
      else if (wait_k > 0 && wait_k < 1000) wait_k++;
      adder_opdone = (wait_k != 0) && (wait_k == cfg_w);
    end
  end

  // ---------------- slave read model: result selected by the last 0x06 write ----------------
  initial begin : slave
    int life;
    life = 0; m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && m_sel && m_wr && m_addr == 8'h06) begin
        m_rdata = res_mem[m_wdata[2:0]];
        life = 1;
      end else if (life > 0) begin
        life--;
      end else begin
        m_rdata = $urandom;
      end
    end
  end

  // ---------------- bus monitor ----------------
  initial begin : bus_mon
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_sel && m_wr) begin
          check("bus_write_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) check("bus_write", {m_addr, m_wdata}, exp_q.pop_front());
          if (m_addr == 8'h00) check("wr_a_needs_valid", in_valid, 1'b1);
        end else if (!m_sel) begin
          check("bus_idle_zero", {m_wr, m_addr, m_wdata}, 64'd0);
        end
      end
    end
  end

  // ---------------- result monitor ----------------
  initial begin : res_mon
    bit          held_v;
    logic [34:0] held;
    held_v = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        check("rcap_bus_quiet", m_sel, 1'b0);
        if (!held_v) begin
          held_v = 1'b1;
          held   = {out_idx, out_data};
        end else begin
          check("out_stable", {out_idx, out_data}, held);
        end
        if (out_ready) begin
          held_v = 1'b0;
          check("result_expected", 64'(res_q.size() > 0), 64'd1);
          if (res_q.size() > 0) check("result", {out_idx, out_data}, res_q.pop_front());
        end
      end
    end
  end

  // ---------------- job preparation and running ----------------
  task automatic prepare_job(input int w, input bit rnd, input int gp, input int gl,
                             input int si, input int sl, input bit timeout);
    cfg_w = w; cfg_rand = rnd;
    cfg_gap_pair = gp; cfg_gap_len = gl;
    cfg_stall_idx = si; cfg_stall_len = sl;
    for (int p = 0; p < NP; p++) begin
      a_arr[p] = $urandom;
      b_arr[p] = $urandom;
      exp_q.push_back({8'h00, a_arr[p]});
      exp_q.push_back({8'h01, b_arr[p]});
    end
    exp_q.push_back({8'h03, 32'd1});
    exp_q.push_back({8'h04, 32'd1});
    if (!timeout) begin
      for (int i = 0; i < NR; i++) begin
        res_mem[i] = $urandom;
        exp_q.push_back({8'h06, 32'(i)});
        res_q.push_back({3'(i), res_mem[i]});
      end
    end
    exp_q.push_back({8'h05, 32'd1});
    exp_q.push_back({8'h05, 32'd0});
  endtask

  task automatic run_job(input int w, input bit rnd, input int gp, input int gl,
                         input int si, input int sl, input bit pulse_in_wait,
                         input bit timeout, input int exp_lat);
    int n;
    int extra;
    prepare_job(w, rnd, gp, gl, si, sl, timeout);
    @(posedge clk); #1;
    start = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      n++;
      start = pulse_in_wait && (n == 1 + 2 * NP + 2 + 2);
      if (n == 1) begin
        check("busy_after_start", busy, 1'b1);
        check("err_cleared_on_start", err, 1'b0);
      end
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    if (exp_lat >= 0) check("latency", 64'(n), 64'(exp_lat));
    check("err_at_done", err, timeout);
    check("bus_q_drained", 64'(exp_q.size()), 64'd0);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) check("done_one_cycle", done, 1'b0);
      if (done) extra++;
    end
    check("no_extra_done", 64'(extra), 64'd0);
    check("idle_after_done", {busy, in_ready, out_valid}, 64'd0);
    check("err_sticky", err, timeout);
    exp_q.delete();
    res_q.delete();
  endtask

  task automatic reset_mid_rcap();
    int n;
    prepare_job(3, 1'b0, 0, 0, 3, 20, 1'b0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (out_valid && !out_ready && out_idx == 3'd3) break;
      @(posedge clk); #1;
      n++;
    end
    check("reached_rcap", {out_valid, out_ready, out_idx}, {1'b1, 1'b0, 3'd3});
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_ctrl", {in_ready, out_valid, busy, done, err, m_sel, m_wr}, 64'd0);
    check("rst_mid_out", {out_idx, out_data}, 64'd0);
    check("rst_mid_bus", {m_addr, m_wdata}, 64'd0);
    repeat (5) @(negedge clk);
    check("rst_mid_stays_idle", {busy, in_ready, out_valid, done}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    reset = 1'b1; start = 1'b0;
    cfg_w = 0; cfg_rand = 1'b0;
    cfg_gap_pair = 0; cfg_gap_len = 0; cfg_stall_idx = 0; cfg_stall_len = 0;
    for (int i = 0; i < NP; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    for (int i = 0; i < NR; i++) res_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, busy, done, err, m_sel, m_wr}, 64'd0);
    check("reset_out", {out_idx, out_data}, 64'd0);
    check("reset_bus", {m_addr, m_wdata}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // clean jobs with different WAIT dwell
    run_job(5, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, job_latency(5));
    run_job(1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, job_latency(1));
    // operand gap in the middle of the load phase
    run_job(3, 1'b0, 3, 4, 0, 0, 1'b0, 1'b0, -1);
    // result stall on index 2
    run_job(2, 1'b0, 0, 0, 2, 4, 1'b0, 1'b0, -1);
    // start pulsed during WAIT is ignored
    run_job(6, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, job_latency(6));
    // reset while a result is pending, then a normal job
    reset_mid_rcap();
    run_job(4, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, job_latency(4));
`ifdef TIMEOUT_EN
    // adder never completes: watchdog ends the job after TO WAIT cycles
    run_job(0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1 + 2 * NP + 2 + TO + 2);
`else
    // no watchdog: a dwell well beyond TO still completes normally
    run_job(40, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, job_latency(40));
`endif
    run_job(5, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, job_latency(5));
    // randomized handshakes
    for (int j = 0; j < 3; j++) begin
      run_job(int'($urandom_range(1, 10)), 1'b1, 0, 0, 0, 0, 1'b0, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "time limit");
  end

endmodule
